// File: rtl/hack_run_ctrl_if.sv
// Program-load stream from the host loader into the Hack run controller.
// Valid/ready handshake carrying one 16-bit word per transfer plus a last-word marker.
interface hack_run_ctrl_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/hack_run_ctrl.sv
// Hack CPU run controller: streams a program into ROM, pulses CPU reset, runs to halt or budget.
// Optional macro HALT_DETECT_EN enables pc-loop halt detection; without it every run is fixed-length.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; CPU held in reset
// S_LOAD | accepting program words into ROM
// S_RST  | one-cycle CPU reset pulse after load; pc history cleared
// S_RUN  | CPU released; counting cycles, watching for halt or budget
// S_DONE | run finished; CPU held in reset, results held
module hack_run_ctrl #(
  parameter int ROM_AW     = 4,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  hack_run_ctrl_if.slave    ld,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  input  logic [15:0]       cpu_pc,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RST  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;
  localparam logic [15:0]       CYC_LIMIT = 16'(MAX_CYCLES);
  localparam logic [15:0]       CYC_SAT   = 16'hFFFF;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       cycles_q, cycles_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              load_ready_q, load_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              halt;
  logic [15:0]       cycles_inc;

`ifdef HALT_DETECT_EN
  localparam logic BUDGET_TIMEOUT = 1'b1;

  logic [15:0] pc_d1_q, pc_d1_d;
  logic [15:0] pc_d2_q, pc_d2_d;
  logic [1:0]  hist_cnt_q, hist_cnt_d;

  // A repeat of either of the last two pcs means the program sits in its terminal loop.
  always_comb begin
    pc_d1_d    = pc_d1_q;
    pc_d2_d    = pc_d2_q;
    hist_cnt_d = hist_cnt_q;
    halt       = (hist_cnt_q == 2'd2) &&
                 ((cpu_pc == pc_d1_q) || (cpu_pc == pc_d2_q));
    if (!abort) begin
      if (state_q == S_RST) begin
        pc_d1_d    = '0;
        pc_d2_d    = '0;
        hist_cnt_d = 2'd0;
      end else if (state_q == S_RUN) begin
        pc_d1_d = cpu_pc;
        pc_d2_d = pc_d1_q;
        if (hist_cnt_q != 2'd2) begin
          hist_cnt_d = hist_cnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_d1_q    <= '0;
      pc_d2_q    <= '0;
      hist_cnt_q <= 2'd0;
    end else begin
      pc_d1_q    <= pc_d1_d;
      pc_d2_q    <= pc_d2_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end
`else
  // Fixed-length runs: budget expiry is the normal end, not a timeout.
  localparam logic BUDGET_TIMEOUT = 1'b0;

  logic unused_pc;
  assign unused_pc = ^cpu_pc;
  assign halt      = 1'b0;
`endif

  assign accept     = ld.load_valid & load_ready_q;
  assign cycles_inc = (cycles_q == CYC_SAT) ? cycles_q : cycles_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cycles_d   = cycles_q;
    done_d     = done_q;
    timeout_d  = timeout_q;

    if (abort) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_LOAD;
            rom_addr_d = '0;
            cycles_d   = '0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (ld.load_last || (rom_addr_q == ADDR_LAST)) begin
              rom_addr_d = '0;
              state_d    = S_RST;
            end else begin
              rom_addr_d = rom_addr_q + 1'b1;
            end
          end
        end
        S_RST: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          cycles_d = cycles_inc;
          // Halt takes priority when it coincides with budget exhaustion.
          if (halt) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (cycles_inc >= CYC_LIMIT) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = BUDGET_TIMEOUT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    load_ready_d = (state_d == S_LOAD);
    cpu_reset_d  = (state_d != S_RUN);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RST) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      load_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      cycles_q     <= cycles_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      load_ready_q <= load_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign ld.load_ready = load_ready_q;
  assign rom_we        = accept;
  assign rom_addr      = rom_addr_q;
  assign rom_wdata     = ld.load_data;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign cycles        = cycles_q;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Bench for hack_run_ctrl: ROM writes and run results go through expected-value queues
// checked by a negedge monitor; state snapshots are checked inline by the stimulus.
module tb_hack_run_ctrl;

`ifdef HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        to;
    logic [15:0] cyc;
  } dn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rom_we;
  logic [3:0]  rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic [15:0] cpu_pc = 16'd0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  wr_t         exp_wr[$];
  dn_t         exp_dn[$];
  logic [15:0] pc_seq[$];
  logic        done_prev = 1'b0;

  hack_run_ctrl_if ld_if ();

  hack_run_ctrl #(
    .ROM_AW    (4),
    .MAX_CYCLES(20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .ld       (ld_if),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset),
    .cpu_pc   (cpu_pc),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ROM write and every rising done is matched against the queues.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (reset) begin
      if (rom_we) begin
        if (exp_wr.size() == 0) begin
          fail_bound("rom_we_unexpected");
        end else begin
          w = exp_wr.pop_front();
          chk("rom_addr", 32'(rom_addr), 32'(w.addr));
          chk("rom_wdata", 32'(rom_wdata), 32'(w.data));
        end
      end
      if (done && !done_prev) begin
        if (exp_dn.size() == 0) begin
          fail_bound("done_unexpected");
        end else begin
          d = exp_dn.pop_front();
          chk("timeout", 32'(timeout), 32'(d.to));
          chk("cycles", 32'(cycles), 32'(d.cyc));
        end
      end
    end
    done_prev <= done;
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input int last_idx, input logic [15:0] base);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!ld_if.load_ready && w < 20) begin
        tick();
        w++;
      end
      if (!ld_if.load_ready) begin
        fail_bound("load_ready_wait");
        ld_if.load_valid = 1'b0;
        return;
      end
      exp_wr.push_back('{addr: 4'(i % 16), data: base + 16'(i)});
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = base + 16'(i);
      ld_if.load_last  = (i == last_idx);
      tick();
    end
    ld_if.load_valid = 1'b0;
    ld_if.load_last  = 1'b0;
  endtask

  task automatic run_pc(input int start_at, input int abort_at, input int budget);
    int i;
    i = 0;
    while (cpu_reset && i < budget) begin
      tick();
      i++;
    end
    if (cpu_reset) begin
      fail_bound("run_entry");
      return;
    end
    i = 0;
    while (!done && i < budget) begin
      if (i < pc_seq.size()) cpu_pc = pc_seq[i];
      else cpu_pc = pc_seq[pc_seq.size()-1] + 16'(i - pc_seq.size() + 1);
      start = (i == start_at);
      abort = (i == abort_at);
      tick();
      start = 1'b0;
      if (i == abort_at) begin
        abort = 1'b0;
        return;
      end
      i++;
    end
    if (!done) fail_bound("run_done");
  endtask

  initial begin
    ld_if.load_valid = 1'b0;
    ld_if.load_data  = 16'd0;
    ld_if.load_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_load_ready", 32'(ld_if.load_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Six-word load, one RST cycle, then halt on pc loop (or budget without detection)
    pulse_start();
    chk("load_ready_in_load", 32'(ld_if.load_ready), 32'd1);
    load_words(6, 5, 16'hA000);
    chk("t1_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t1_rst_load_ready", 32'(ld_if.load_ready), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd1);
    chk("t1_rst_rom_addr", 32'(rom_addr), 32'd0);
    tick();
    chk("t1_run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t1_run_busy", 32'(busy), 32'd1);
    pc_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd4};
    exp_dn.push_back('{to: 1'b0, cyc: HD ? 16'd7 : 16'd20});
    run_pc(-1, -1, 60);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    tick();

    // Budget expiry with steadily incrementing pc; start during RUN must be ignored
    pulse_start();
    load_words(2, 1, 16'hB000);
    pc_seq = '{16'd0};
    exp_dn.push_back('{to: HD, cyc: 16'd20});
    run_pc(4, -1, 60);
    chk("t3_done", 32'(done), 32'd1);
    tick();
    chk("t3_done_held", 32'(done), 32'd1);
    chk("t3_cycles_held", 32'(cycles), 32'd20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_done", 32'(done), 32'd0);
    chk("t3_abort_timeout", 32'(timeout), 32'd0);
    chk("t3_abort_cycles", 32'(cycles), 32'd20);
    chk("t3_abort_cpu_reset", 32'(cpu_reset), 32'd1);

    // Sixteen words without load_last fill the ROM and wrap the pointer
    pulse_start();
    load_words(16, -1, 16'hC000);
    chk("t4_rom_addr", 32'(rom_addr), 32'd0);
    chk("t4_load_ready", 32'(ld_if.load_ready), 32'd0);
    chk("t4_cpu_reset_rst", 32'(cpu_reset), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);

    // Abort in RUN cycle 3, then a reload starts from address 0
    pc_seq = '{16'd0, 16'd1, 16'd2};
    run_pc(-1, 2, 60);
    chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_load_ready", 32'(ld_if.load_ready), 32'd0);
    tick();
    pulse_start();
    load_words(3, 2, 16'hD000);
    pc_seq = '{16'd0, 16'd1, 16'd1};
    exp_dn.push_back('{to: 1'b0, cyc: HD ? 16'd3 : 16'd20});
    run_pc(-1, -1, 60);
    tick();

    // Asynchronous reset in the middle of a load
    pulse_start();
    load_words(3, -1, 16'hE000);
    chk("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_load_ready", 32'(ld_if.load_ready), 32'd0);
    chk("t6_rom_addr", 32'(rom_addr), 32'd0);
    chk("t6_cycles", 32'(cycles), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();

    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    chk("exp_dn_drained", 32'(exp_dn.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
